rf_wbq: RTL and testbench

RF_WBQ -- requirements
Module: rf_wbq

---
 rtl/rf_wbq.sv | 154 +++++++++++++++
 tb/tb_rf_wbq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wbq.sv
// Register-file writeback queue: buffers writes until the RF write port is free,
// with a register-hazard lookup port and a flush/drain handshake.
module rf_wbq #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned XWDT  = 6,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XWDT-1:0] req_reg,
    input  logic [XLEN-1:0] req_data,
    input  logic [1:0]      req_size,
    input  logic [2:0]      req_pos,
    input  logic            rf_busy,
    output logic            rf_we,
    output logic [XWDT-1:0] rf_wreg,
    output logic [XLEN-1:0] rf_wdata,
    output logic [1:0]      rf_wsize,
    output logic [2:0]      rf_wpos,
    input  logic [XWDT-1:0] chk_reg,
    output logic            chk_pending,
    input  logic            flush,
    output logic            flush_done,
    output logic            err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t          state_q;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   head_q, tail_q;
    logic            rf_we_q, err_q, flush_done_q;
    logic [XWDT-1:0] rf_wreg_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic [1:0]      rf_wsize_q;
    logic [2:0]      rf_wpos_q;

    logic [XWDT-1:0] mem_reg_q  [DEPTH];
    logic [XLEN-1:0] mem_data_q [DEPTH];
    logic [1:0]      mem_size_q [DEPTH];
    logic [2:0]      mem_pos_q  [DEPTH];

    logic [3:0]      lane_limit;
    logic            legal, accept, push, pop;
    logic [AW-1:0]   offset;

    assign req_ready = (count_q < CW'(DEPTH)) && (state_q != DRAIN) && !rst;

    always_comb begin
        lane_limit = 4'd8 >> req_size;
        legal      = {1'b0, req_pos} < lane_limit;
        accept     = req_valid && req_ready;
        push       = accept && legal;
        pop        = (count_q != '0) && !rf_busy;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // An entry is occupied when its distance from head (mod DEPTH) is below count.
    always_comb begin
        chk_pending = rf_we_q && (rf_wreg_q == chk_reg);
        offset      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = AW'(i) - head_q;
            if (({1'b0, offset} < count_q) && (mem_reg_q[i] == chk_reg)) begin
                chk_pending = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg_q[tail_q]  <= req_reg;
            mem_data_q[tail_q] <= req_data;
            mem_size_q[tail_q] <= req_size;
            mem_pos_q[tail_q]  <= req_pos;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            rf_we_q      <= 1'b0;
            rf_wreg_q    <= '0;
            rf_wdata_q   <= '0;
            rf_wsize_q   <= '0;
            rf_wpos_q    <= '0;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            err_q        <= accept && !legal;
            flush_done_q <= 1'b0;
            if (push) begin
                tail_q <= tail_q + AW'(1);
            end
            if (pop) begin
                head_q     <= head_q + AW'(1);
                rf_we_q    <= 1'b1;
                rf_wreg_q  <= mem_reg_q[head_q];
                rf_wdata_q <= mem_data_q[head_q];
                rf_wsize_q <= mem_size_q[head_q];
                rf_wpos_q  <= mem_pos_q[head_q];
            end else begin
                rf_we_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (flush) begin
                        state_q <= DRAIN;
                    end else if (push) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (flush) begin
                        state_q <= DRAIN;
                    end else if (count_d == '0) begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    // Wait for the final write strobe to retire before signalling done.
                    if ((count_q == '0) && !rf_we_q) begin
                        state_q      <= IDLE;
                        flush_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_wreg    = rf_wreg_q;
    assign rf_wdata   = rf_wdata_q;
    assign rf_wsize   = rf_wsize_q;
    assign rf_wpos    = rf_wpos_q;
    assign err        = err_q;
    assign flush_done = flush_done_q;

endmodule

// File: tb/tb_rf_wbq.sv
// Scoreboard bench for rf_wbq: directed stimulus pushes expected writes, a
// negedge monitor pops and compares every rf_we cycle.
module tb_rf_wbq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [5:0]  req_reg;
    logic [63:0] req_data;
    logic [1:0]  req_size;
    logic [2:0]  req_pos;
    logic        rf_busy, rf_we;
    logic [5:0]  rf_wreg;
    logic [63:0] rf_wdata;
    logic [1:0]  rf_wsize;
    logic [2:0]  rf_wpos;
    logic [5:0]  chk_reg;
    logic        chk_pending, flush, flush_done, err;

    typedef struct packed {
        logic [5:0]  r;
        logic [63:0] d;
        logic [1:0]  s;
        logic [2:0]  p;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  errors = 0;
    int  checks = 0;

    // Legality vectors: size/pos pairs around the lane-count boundary.
    logic [1:0] v_s  [6] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b10};
    logic [2:0] v_p  [6] = '{3'd2,  3'd7,  3'd4,  3'd3,  3'd1,  3'd1};
    logic       v_lg [6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};

    logic       fl_we  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       fl_fd  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       fl_rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    rf_wbq #(.XLEN(64), .XWDT(6), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_reg(req_reg), .req_data(req_data), .req_size(req_size), .req_pos(req_pos),
        .rf_busy(rf_busy), .rf_we(rf_we), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
        .rf_wsize(rf_wsize), .rf_wpos(rf_wpos),
        .chk_reg(chk_reg), .chk_pending(chk_pending),
        .flush(flush), .flush_done(flush_done), .err(err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [5:0] r, input logic [63:0] d, input logic [1:0] s,
                        input logic [2:0] p, input logic legal);
        int unsigned w = 0;
        req_valid = 1'b1; req_reg = r; req_data = d; req_size = s; req_pos = p;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        if (!req_ready) begin
            check("push_ready_timeout", req_ready, 1'b1);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        check("err_after_accept", err, !legal);
        if (legal) sb.push_back(wr_t'({r, d, s, p}));
    endtask

    always @(negedge clk) begin
        if (rf_we) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d expected no write at %0t", rf_wreg, $time);
            end else begin
                mon_e = sb.pop_front();
                check("wr_reg", rf_wreg, mon_e.r);
                check("wr_data", rf_wdata, mon_e.d);
                check("wr_size_pos", {rf_wsize, rf_wpos}, {mon_e.s, mon_e.p});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_reg = '0; req_data = '0; req_size = '0;
        req_pos = '0; rf_busy = 1'b0; chk_reg = '0; flush = 1'b0;
        tick(); tick();
        check("rst_ready", req_ready, 1'b0);
        check("rst_we", rf_we, 1'b0);
        check("rst_wreg", rf_wreg, 6'd0);
        check("rst_wdata", rf_wdata, 64'd0);
        check("rst_wsize_pos", {rf_wsize, rf_wpos}, 5'd0);
        check("rst_err", err, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_chk_pending", chk_pending, 1'b0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", req_ready, 1'b1);

        // Single full-width write and its latency.
        push(6'd5, 64'h1122334455667788, 2'b11, 3'd0, 1'b1);
        check("lat_we_n", rf_we, 1'b0);
        tick();
        check("lat_we_n1", rf_we, 1'b1);
        tick();
        check("lat_we_n2", rf_we, 1'b0);
        check("lat_ready", req_ready, 1'b1);

        // Fill under stall, refuse a fifth request, then release.
        rf_busy = 1'b1;
        for (int i = 1; i <= 4; i++) push(6'(i), 64'hA000_0000_0000_0000 | 64'(i), 2'b11, 3'd0, 1'b1);
        check("full_ready", req_ready, 1'b0);
        req_valid = 1'b1; req_reg = 6'd15; req_data = 64'hDEAD; req_size = 2'b11; req_pos = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_accept", req_ready, 1'b0);
        end
        req_valid = 1'b0;
        rf_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("burst_we", rf_we, k < 4);
        end

        // Legality boundaries.
        for (int i = 0; i < 6; i++) begin
            push(6'(10 + i), 64'h5500 + 64'(i), v_s[i], v_p[i], v_lg[i]);
            tick();
            check("vec_we", rf_we, v_lg[i]);
            check("err_clear", err, 1'b0);
            tick();
        end

        // Hazard lookup across queued and in-flight phases.
        rf_busy = 1'b1;
        push(6'd9, 64'h99, 2'b11, 3'd0, 1'b1);
        chk_reg = 6'd9; #1;
        check("haz_queued_hit", chk_pending, 1'b1);
        chk_reg = 6'd8; #1;
        check("haz_miss", chk_pending, 1'b0);
        chk_reg = 6'd9; rf_busy = 1'b0; #1;
        check("haz_queued_hit2", chk_pending, 1'b1);
        tick();
        check("haz_inflight_we", rf_we, 1'b1);
        check("haz_inflight_hit", chk_pending, 1'b1);
        tick();
        check("haz_done_we", rf_we, 1'b0);
        check("haz_done", chk_pending, 1'b0);
        tick();

        // Flush with three entries; requests during drain are refused.
        rf_busy = 1'b1;
        for (int i = 0; i < 3; i++) push(6'(30 + i), 64'hF0 + 64'(i), 2'b10, 3'd1, 1'b1);
        flush = 1'b1; rf_busy = 1'b0;
        tick();
        req_valid = 1'b1; req_reg = 6'd33; req_data = 64'hBAD; req_size = 2'b11; req_pos = 3'd0;
        for (int k = 0; k < 7; k++) begin
            check("flush_we", rf_we, fl_we[k]);
            check("flush_done", flush_done, fl_fd[k]);
            check("flush_ready", req_ready, fl_rdy[k]);
            if (k == 1) flush = 1'b0;
            if (k == 3) req_valid = 1'b0;
            tick();
        end

        // Reset asserted off-edge in the middle of a drain.
        rf_busy = 1'b1;
        push(6'd40, 64'h40, 2'b11, 3'd0, 1'b1);
        push(6'd41, 64'h41, 2'b11, 3'd0, 1'b1);
        flush = 1'b1; rf_busy = 1'b0;
        tick();
        flush = 1'b0;
        check("drain_we_before_rst", rf_we, 1'b1);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check("rst_async_we", rf_we, 1'b0);
        check("rst_async_ready", req_ready, 1'b0);
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_no_we", rf_we, 1'b0);
        end
        check("post_rst_ready", req_ready, 1'b1);
        chk_reg = 6'd41; #1;
        check("post_rst_chk41", chk_pending, 1'b0);
        chk_reg = 6'd40; #1;
        check("post_rst_chk40", chk_pending, 1'b0);

        tick(); tick();
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
